// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes a MIPS instruction into ALU op/operands, runs the
// ALU for one cycle and registers the result. Optional macro: SHIFT_VAR_EN (SLLV/SRLV).
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            req_opcode,
  input  logic [5:0]            req_funct,
  input  logic [4:0]            req_shamt,
  input  logic [DATA_WIDTH-1:0] req_rs_data,
  input  logic [DATA_WIDTH-1:0] req_rt_data,
  input  logic [15:0]           req_imm,
  output logic [3:0]            ALUOperation,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_zero,
  output logic                  rsp_illegal
);

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_NOR = 4'd2,
    ALU_ADD = 4'd3,
    ALU_SUB = 4'd4,
    ALU_LUI = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;

  state_e                state_q, state_d;
  alu_op_e               op_q, dec_op;
  logic [DATA_WIDTH-1:0] a_q, b_q, dec_b;
  logic [4:0]            shamt_q, dec_shamt;
  logic                  illegal_q, dec_legal;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_zero_q, rsp_illegal_q;
  logic                  load, capture;

  logic [DATA_WIDTH-1:0] imm_sext, imm_zext;
  assign imm_sext = {{(DATA_WIDTH-16){req_imm[15]}}, req_imm};
  assign imm_zext = {{(DATA_WIDTH-16){1'b0}}, req_imm};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_op    = ALU_AND;
    dec_b     = '0;
    dec_shamt = '0;
    dec_legal = 1'b1;
    case (req_opcode)
      OP_RTYPE: begin
        dec_b     = req_rt_data;
        dec_shamt = req_shamt;
        case (req_funct)
          FN_ADD, FN_ADDU: dec_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec_op = ALU_SUB;
          FN_AND:          dec_op = ALU_AND;
          FN_OR:           dec_op = ALU_OR;
          FN_NOR:          dec_op = ALU_NOR;
          FN_SLL:          dec_op = ALU_SLL;
          FN_SRL:          dec_op = ALU_SRL;
`ifdef SHIFT_VAR_EN
          FN_SLLV: begin
            dec_op    = ALU_SLL;
            dec_shamt = req_rs_data[4:0];
          end
          FN_SRLV: begin
            dec_op    = ALU_SRL;
            dec_shamt = req_rs_data[4:0];
          end
`endif
          default:         dec_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        dec_op = ALU_ADD;
        dec_b  = imm_sext;
      end
      OP_ANDI: begin
        dec_op = ALU_AND;
        dec_b  = imm_zext;
      end
      OP_ORI: begin
        dec_op = ALU_OR;
        dec_b  = imm_zext;
      end
      OP_LUI: begin
        dec_op = ALU_LUI;
        dec_b  = imm_zext;
      end
      OP_BEQ, OP_BNE: begin
        dec_op = ALU_SUB;
        dec_b  = req_rt_data;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign req_ready = reset & ((state_q == S_IDLE) | ((state_q == S_DONE) & rsp_ready));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          load    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        capture = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          if (req_valid) begin
            load    = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Illegal requests park the ALU on AND of zeros so nothing spurious toggles downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= ALU_AND;
      a_q       <= '0;
      b_q       <= '0;
      shamt_q   <= '0;
      illegal_q <= 1'b0;
    end else if (load) begin
      op_q      <= dec_legal ? dec_op : ALU_AND;
      a_q       <= dec_legal ? req_rs_data : '0;
      b_q       <= dec_legal ? dec_b : '0;
      shamt_q   <= dec_legal ? dec_shamt : '0;
      illegal_q <= ~dec_legal;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b1;
      rsp_illegal_q <= 1'b0;
    end else if (capture) begin
      rsp_data_q    <= illegal_q ? '0 : alu_result;
      rsp_zero_q    <= illegal_q | (alu_result == '0);
      rsp_illegal_q <= illegal_q;
    end
  end

  assign ALUOperation = op_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_shamt    = shamt_q;
  assign rsp_valid    = (state_q == S_DONE);
  assign rsp_data     = rsp_data_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_illegal  = rsp_illegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front end for the 32-bit ALU: accepts a decoded MIPS instruction (opcode, funct, shamt, register operands, immediate) over a valid/ready handshake. Translates it into the 4-bit ALU operation code and operands, drives the combinational ALU for one cycle, and registers the ALU result for the writeback stage behind a second valid/ready handshake. It is the producer side of the ALU operation interface, sitting between the decode stage and the ALU.

## Interface
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on a clock edge when req_valid=1
- req_opcode  in  6  instruction opcode
- req_funct  in  6  R-type funct field
- req_shamt  in  5  R-type shift amount
- req_rs_data  in  32  rs register value
- req_rt_data  in  32  rt register value
- req_imm  in  16  I-type immediate
- ALUOperation  out  4  ALU op code: AND=0, OR=1, NOR=2, ADD=3, SUB=4, LUI=5, SLL=6, SRL=7
- alu_a, alu_b  out  32  ALU operands
- alu_shamt  out  5  ALU shift amount
- alu_result  in  32  combinational ALU result
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed on a clock edge when rsp_valid=1
- rsp_data  out  32  registered result
- rsp_zero  out  1  rsp_data == 0
- rsp_illegal  out  1  request did not decode; rsp_data=0

## Operation
- **Decode, opcode 0x00 by funct:**
  - 0x20/0x21 ADD, 0x22/0x23 SUB
  - 0x24 AND, 0x25 OR, 0x27 NOR
  - 0x00 SLL, 0x02 SRL
- **R-type operands:** a=rs, b=rt, shamt=req_shamt.
- **I-type:**
  - 0x08/0x09/0x23/0x2B → ADD, b = sign-extended imm
  - 0x0C → AND, 0x0D → OR, b = zero-extended imm
  - 0x0F → LUI, b = zero-extended imm
  - 0x04/0x05 → SUB, b=rt
  - a=rs for all; shamt=0.
- **Illegal decode:** any other opcode/funct combination is illegal.
  - Op/operand registers load AND/0/0/0.
  - Result forced to 0, rsp_illegal=1.
- **FSM states:**
  - IDLE: req_ready=1; accept → EXEC.
  - EXEC: ALU outputs hold registered op/operands; on the edge, alu_result (or 0 if illegal) → rsp_data, rsp_zero and rsp_illegal update; → DONE.
  - DONE: rsp_valid=1. If rsp_ready=0, stay. If rsp_ready=1 and req_valid=1, accept the new request and go to EXEC. If rsp_ready=1 and req_valid=0, go to IDLE.
- **req_ready** = (state==IDLE) | (state==DONE & rsp_ready); forced 0 while reset is asserted.
- **Register loading:** ALUOperation/alu_a/alu_b/alu_shamt are registers loaded only on accept. They hold their values in DONE and IDLE.
- **Response stability:** rsp_data/rsp_zero/rsp_illegal stay stable while rsp_valid=1 and rsp_ready=0.
- **Reset mid-operation:** asynchronous return to IDLE; any in-flight request or result is discarded.

## Timing
- **Reset values:** state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_data=0, rsp_zero=1, rsp_illegal=0, ALUOperation=0, alu_a=0, alu_b=0, alu_shamt=0.
- **Latency:** request accepted at edge N → ALU inputs valid after N → rsp_valid=1 after edge N+1.
- **Throughput:** one request per 2 cycles with rsp_ready held high; back-to-back through DONE→EXEC.
- **Backpressure:** rsp_ready low stalls indefinitely with no request lost; req_ready stays 0 during the stall.
- **ALU path:** the ALU sits combinationally between the registered outputs and alu_result; one full cycle is budgeted.

## Configuration
- **SHIFT_VAR_EN defined:** funct 0x04 (SLLV) → SLL and 0x06 (SRLV) → SRL, with b=rt and shamt=rs[4:0].
- **SHIFT_VAR_EN undefined:** funct 0x04/0x06 decode as illegal.

## Test plan
- **Reset:** reset low mid-EXEC → rsp_valid=0, req_ready=0, rsp_data=0, rsp_zero=1 immediately. Release → req_ready=1 next cycle.
- **ADD:** opcode 0x00, funct 0x20, rs=0x7FFFFFFF, rt=1 → ALUOperation=3, and rsp_data=0x80000000 with rsp_valid 2 cycles after accept.
- **Immediates:**
  - addi with imm=0xFFFF, rs=5 → alu_b=0xFFFFFFFF, rsp_data=4.
  - ori with imm=0xFFFF, rs=0 → rsp_data=0x0000FFFF.
  - lui with imm=0x1234 → rsp_data=0x12340000.
- **Branch compare:** beq with rs=rt=0xA5A5A5A5 → ALUOperation=4, rsp_data=0, rsp_zero=1.
- **Backpressure:** rsp_ready=0 for 5 cycles after an SRL (rt=0x80000000, shamt=31) → rsp_data=1 held stable, req_ready=0. Raising rsp_ready with req_valid high accepts the next request on the same edge.
- **Illegal/variable shift:** funct 0x04, rs=4, rt=3:
  - With SHIFT_VAR_EN → rsp_data=0x30, rsp_illegal=0.
  - Without → rsp_data=0, rsp_illegal=1.
  - Opcode 0x3F → rsp_illegal=1 in both builds.
